// File: rtl/alarm_time_controller.sv
// Alarm-clock timekeeping: divides the tick pulse into seconds, chains
// seconds/minutes/hours, and runs the RUN / SET_TIME / SET_ALARM / RINGING modes.
module alarm_time_controller #(
    parameter int TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [1:0] sw,
    input  logic       btn_min,
    input  logic       btn_hr,
    input  logic       alarm_en,
    input  logic       alarm_ack,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_minutes,
    output logic       ringing,
    output logic       sec_pulse,
    output logic       disp_alarm
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2,
        RINGING   = 2'd3
    } state_e;

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

    state_e     state_q, state_d;
    logic [7:0] tick_cnt_q, tick_cnt_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;
    logic [4:0] hr_q, hr_d;
    logic [5:0] al_min_q, al_min_d;
    logic [4:0] al_hr_q, al_hr_d;
    logic       sec_pulse_q, sec_pulse_d;

    state_e sw_state;
    logic   timebase_on;
    logic   sec_carry;
    logic   alarm_hit;

    always_comb begin
        case (sw)
            2'b01:   sw_state = SET_TIME;
            2'b10:   sw_state = SET_ALARM;
            default: sw_state = RUN;
        endcase
    end

    // Timebase, button handling and next-state decode.
    always_comb begin
        tick_cnt_d  = tick_cnt_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hr_d        = hr_q;
        al_min_d    = al_min_q;
        al_hr_d     = al_hr_q;
        sec_pulse_d = 1'b0;
        state_d     = state_q;

        timebase_on = (state_q != SET_TIME);
        sec_carry   = timebase_on && tick && (tick_cnt_q == TICK_LAST);

        if (timebase_on && tick) begin
            tick_cnt_d = sec_carry ? 8'd0 : tick_cnt_q + 8'd1;
        end

        if (sec_carry) begin
            sec_pulse_d = 1'b1;
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d = 6'd0;
                    hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end

        if (state_q == SET_TIME) begin
            if (btn_min) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            if (btn_hr)  hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        end

        if (state_q == SET_ALARM) begin
            if (btn_min) al_min_d = (al_min_q == 6'd59) ? 6'd0 : al_min_q + 6'd1;
            if (btn_hr)  al_hr_d  = (al_hr_q == 5'd23) ? 5'd0 : al_hr_q + 5'd1;
        end

        // Edge-based: only a carry that lands exactly on hh:mm:00 arms the ring.
        alarm_hit = alarm_en && sec_carry && (sec_d == 6'd0) &&
                    (min_d == al_min_q) && (hr_d == al_hr_q);

        case (state_q)
            RINGING: if (alarm_ack) state_d = RUN;
            RUN:     state_d = alarm_hit ? RINGING : sw_state;
            default: state_d = sw_state;
        endcase

        if (state_d == SET_TIME && state_q != SET_TIME) begin
            sec_d       = 6'd0;
            tick_cnt_d  = 8'd0;
            sec_pulse_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            tick_cnt_q  <= 8'd0;
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            hr_q        <= 5'd0;
            al_min_q    <= 6'd0;
            al_hr_q     <= 5'd0;
            sec_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hr_q        <= hr_d;
            al_min_q    <= al_min_d;
            al_hr_q     <= al_hr_d;
            sec_pulse_q <= sec_pulse_d;
        end
    end

    assign hours         = hr_q;
    assign minutes       = min_q;
    assign seconds       = sec_q;
    assign alarm_hours   = al_hr_q;
    assign alarm_minutes = al_min_q;
    assign sec_pulse     = sec_pulse_q;
    assign ringing       = (state_q == RINGING);
    assign disp_alarm    = (state_q == SET_ALARM);

endmodule

// File: tb/tb_alarm_time_controller.sv
// Directed bench for alarm_time_controller at TICK_DIV=2.
module tb_alarm_time_controller;

    logic       clk = 1'b0;
    logic       rst, tick, btn_min, btn_hr, alarm_en, alarm_ack;
    logic [1:0] sw;
    logic [4:0] hours, alarm_hours;
    logic [5:0] minutes, seconds, alarm_minutes;
    logic       ringing, sec_pulse, disp_alarm;

    int errs = 0;
    int checks = 0;
    int sp_cnt, ring_cnt;

    alarm_time_controller #(.TICK_DIV(2)) dut (
        .clk(clk), .rst(rst), .tick(tick), .sw(sw),
        .btn_min(btn_min), .btn_hr(btn_hr),
        .alarm_en(alarm_en), .alarm_ack(alarm_ack),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
        .ringing(ringing), .sec_pulse(sec_pulse), .disp_alarm(disp_alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (sec_pulse) sp_cnt++;
        if (ringing) ring_cnt++;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic press_min(input int n);
        btn_min = 1'b1;
        repeat (n) step();
        btn_min = 1'b0;
    endtask

    task automatic press_hr(input int n);
        btn_hr = 1'b1;
        repeat (n) step();
        btn_hr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; sw = 2'b00; btn_min = 1'b0; btn_hr = 1'b0;
        alarm_en = 1'b1; alarm_ack = 1'b0;
        sp_cnt = 0; ring_cnt = 0;
        step();
        rst = 1'b0;
        chk("rst_hours", hours, 0);
        chk("rst_minutes", minutes, 0);
        chk("rst_seconds", seconds, 0);
        chk("rst_ringing", ringing, 0);
        chk("rst_sec_pulse", sec_pulse, 0);
        chk("rst_disp_alarm", disp_alarm, 0);

        // Reset and run: 4 ticks with idle gaps -> 2 seconds, 2 one-cycle pulses.
        sp_cnt = 0; ring_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1; step();
            tick = 1'b0; step();
        end
        chk("run_seconds", seconds, 2);
        chk("run_sec_pulse_count", sp_cnt, 2);
        chk("run_no_ring_at_reset_match", ring_cnt, 0);
        alarm_en = 1'b0;

        // Set time: entry clears seconds, ticks ignored, buttons adjust.
        sw = 2'b01; step();
        chk("set_entry_seconds", seconds, 0);
        ticks(5);
        chk("set_tick_ignored_sec", seconds, 0);
        chk("set_tick_ignored_min", minutes, 0);
        press_hr(23);
        press_min(59);
        chk("set_hours", hours, 23);
        chk("set_minutes", minutes, 59);
        chk("set_seconds", seconds, 0);
        press_min(1);
        chk("set_min_wrap", minutes, 0);
        chk("set_min_wrap_no_carry", hours, 23);
        press_min(59);

        // Rollover 23:59:00 -> 00:00:00 over 120 ticks.
        sw = 2'b00; step();
        ticks(118);
        chk("roll_pre_hours", hours, 23);
        chk("roll_pre_minutes", minutes, 59);
        chk("roll_pre_seconds", seconds, 59);
        ticks(2);
        chk("roll_hours", hours, 0);
        chk("roll_minutes", minutes, 0);
        chk("roll_seconds", seconds, 0);
        chk("roll_sec_pulse", sec_pulse, 1);

        // Alarm fire and ack at 00:01.
        sw = 2'b10; step();
        chk("sa_disp_alarm", disp_alarm, 1);
        press_min(1);
        chk("sa_alarm_minutes", alarm_minutes, 1);
        chk("sa_alarm_hours", alarm_hours, 0);
        alarm_en = 1'b1;
        ticks(118);
        chk("sa_time_runs", seconds, 59);
        sw = 2'b00; step();
        chk("run_disp_alarm", disp_alarm, 0);
        tick = 1'b1; step();
        chk("pre_fire_ringing", ringing, 0);
        step(); tick = 1'b0;
        chk("fire_minutes", minutes, 1);
        chk("fire_seconds", seconds, 0);
        chk("fire_ringing", ringing, 1);
        sw = 2'b01; press_min(1);
        chk("ring_ignores_sw", disp_alarm, 0);
        chk("ring_ignores_btn", minutes, 1);
        chk("ring_held", ringing, 1);
        ticks(4);
        chk("ring_time_runs", seconds, 2);
        alarm_en = 1'b0; step();
        chk("ring_en_drop", ringing, 1);
        alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
        chk("ack_ringing", ringing, 0);
        chk("ack_seconds", seconds, 2);
        step();
        chk("post_ack_set_time", seconds, 0);

        // Alarm disabled: pass 00:01:00 with alarm_en=0.
        press_min(59);
        chk("dis_setup_min", minutes, 0);
        sw = 2'b10; step();
        ticks(118);
        sw = 2'b00; step();
        ring_cnt = 0;
        ticks(2);
        chk("dis_minutes", minutes, 1);
        chk("dis_seconds", seconds, 0);
        chk("dis_no_ring", ring_cnt, 0);

        // Ring at 00:02:00, then reset mid-ring.
        alarm_en = 1'b1;
        sw = 2'b10; step();
        press_min(1);
        ticks(118);
        sw = 2'b00; step();
        ticks(2);
        chk("ring2_minutes", minutes, 2);
        chk("ring2_ringing", ringing, 1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_rst_hours", hours, 0);
        chk("mid_rst_minutes", minutes, 0);
        chk("mid_rst_seconds", seconds, 0);
        chk("mid_rst_al_hours", alarm_hours, 0);
        chk("mid_rst_al_minutes", alarm_minutes, 0);
        chk("mid_rst_ringing", ringing, 0);
        chk("mid_rst_sec_pulse", sec_pulse, 0);
        chk("mid_rst_disp", disp_alarm, 0);
        step();
        chk("post_rst_no_ring", ringing, 0);

        // Tick on a second boundary together with btn_min in SET_ALARM.
        sw = 2'b10; step();
        tick = 1'b1; step();
        btn_min = 1'b1; step();
        tick = 1'b0; btn_min = 1'b0;
        chk("simul_seconds", seconds, 1);
        chk("simul_al_minutes", alarm_minutes, 1);
        chk("simul_sec_pulse", sec_pulse, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
